// File: rtl/seq_sched_pkg.sv
// -----------------------------------------------------------------------------
// seq_sched_pkg
// Shared types and constants for the serial-sequence-detector scheduler.
//   - state_e  : scheduler FSM states
//   - NSYM     : symbols per word, CNT_W : width of the hit counter
//   - head_sym : the symbol currently at the top of the shift register
// -----------------------------------------------------------------------------
package seq_sched_pkg;

    localparam int DEF_WORD_W = 32;
    localparam int SYM_W      = 2;   // bit1 -> det_b, bit0 -> det_a
    localparam int NSYM       = DEF_WORD_W / SYM_W;
    localparam int CNT_W      = $clog2(NSYM + 1);
    localparam int IDX_W      = $clog2(NSYM);
    localparam int DRN_W      = 3;   // drain counter, covers DET_LAT up to 4

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SHIFT,
        ST_DRAIN,
        ST_DONE
    } state_e;

    // Symbols leave MSB-pair first.
    function automatic logic [SYM_W-1:0] head_sym(input logic [DEF_WORD_W-1:0] sr);
        return sr[DEF_WORD_W-1 -: SYM_W];
    endfunction

endpackage

// File: rtl/sym_shifter.sv
// -----------------------------------------------------------------------------
// sym_shifter
// Loadable word shift register that presents one symbol per shift, with the
// index of the symbol being presented and a flag for the last one.
//   clk, clr_n : clock, synchronous active-low reset
//   load_i     : capture word_i, restart the symbol index at 0
//   shift_i    : advance to the next symbol
//   word_i     : word to scan
//   sym_o      : current symbol (upper pair of the register)
//   idx_o      : index of sym_o within the word
//   last_o     : sym_o is the final symbol of the word
// -----------------------------------------------------------------------------
module sym_shifter
    import seq_sched_pkg::*;
#(
    parameter int WORD_W = DEF_WORD_W
) (
    input  logic              clk,
    input  logic              clr_n,
    input  logic              load_i,
    input  logic              shift_i,
    input  logic [WORD_W-1:0] word_i,
    output logic [SYM_W-1:0]  sym_o,
    output logic [IDX_W-1:0]  idx_o,
    output logic              last_o
);

    logic [WORD_W-1:0] shreg_q, shreg_d;
    logic [IDX_W-1:0]  idx_q, idx_d;

    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        shreg_d = shreg_q;
        idx_d   = idx_q;
        if (load_i) begin
            shreg_d = word_i;
            idx_d   = '0;
        end else if (shift_i) begin
            shreg_d = shreg_q << SYM_W;
            idx_d   = idx_q + 1'b1;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!clr_n) begin
            shreg_q <= '0;
            idx_q   <= '0;
        end else begin
            shreg_q <= shreg_d;
            idx_q   <= idx_d;
        end
    end

    assign sym_o  = head_sym(shreg_q);
    assign idx_o  = idx_q;
    assign last_o = (idx_q == IDX_W'(NSYM - 1));

endmodule

// File: rtl/seq_sym_sched.sv
// -----------------------------------------------------------------------------
// seq_sym_sched
// Feeds a 32-bit word to a two-input serial sequence detector as 16 symbols,
// collects the detector's det_z answers (aligned for its latency) into a
// per-symbol match map and a hit count, and returns them on a valid/ready port.
//   clk, clr_n          : clock, synchronous active-low reset
//   in_valid/in_ready   : word handshake; in_word is the word to scan
//   abort               : cancel the word in flight (LOAD/SHIFT/DRAIN)
//   det_clr/det_b/det_a : detector clear and symbol bits
//   det_z               : detector response
//   out_valid/out_ready : result handshake
//   hit_cnt, match_map  : number of det_z hits, det_z per symbol (bit 0 first)
// WORD_W is expected to match the package word width; NSYM and CNT_W derive
// from it there.
// -----------------------------------------------------------------------------
module seq_sym_sched
    import seq_sched_pkg::*;
#(
    parameter int WORD_W  = DEF_WORD_W,
    parameter int DET_LAT = 1            // 1..4
) (
    input  logic              clk,
    input  logic              clr_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WORD_W-1:0] in_word,
    input  logic              abort,
    output logic              det_clr,
    output logic              det_b,
    output logic              det_a,
    input  logic              det_z,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CNT_W-1:0]  hit_cnt,
    output logic [NSYM-1:0]   match_map
);

    state_e            state_q, state_d;
    logic              aborting_q, aborting_d;   // current LOAD is an abort flush
    logic [DRN_W-1:0]  drain_q, drain_d;
    logic              det_clr_q;
    logic [CNT_W-1:0]  hit_q, hit_d;
    logic [NSYM-1:0]   map_q, map_d;

    // Tag pipe: which symbol det_z answers for in the current cycle.
    logic              pipe_vld_q [DET_LAT];
    logic [IDX_W-1:0]  pipe_idx_q [DET_LAT];

    logic [SYM_W-1:0]  sh_sym;
    logic [IDX_W-1:0]  sh_idx;
    logic              sh_last;

    logic accept;
    logic abort_take;
    logic sample_en;

    assign accept     = (state_q == ST_IDLE) && in_valid;
    assign abort_take = abort && (state_q inside {ST_LOAD, ST_SHIFT, ST_DRAIN});
    assign sample_en  = pipe_vld_q[DET_LAT-1] && (state_q inside {ST_SHIFT, ST_DRAIN});

    sym_shifter #(
        .WORD_W (WORD_W)
    ) u_shifter (
        .clk     (clk),
        .clr_n   (clr_n),
        .load_i  (accept),
        .shift_i (state_q == ST_SHIFT),
        .word_i  (in_word),
        .sym_o   (sh_sym),
        .idx_o   (sh_idx),
        .last_o  (sh_last)
    );

    // ---------------- next state ----------------
    always_comb begin
        state_d    = state_q;
        aborting_d = aborting_q;
        drain_d    = drain_q;
        unique case (state_q)
            ST_IDLE: begin
                aborting_d = 1'b0;
                if (in_valid) state_d = ST_LOAD;
            end
            ST_LOAD: begin
                if (aborting_q) begin
                    state_d    = ST_IDLE;
                    aborting_d = 1'b0;
                end else begin
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (sh_last) begin
                    state_d = ST_DRAIN;
                    drain_d = '0;
                end
            end
            ST_DRAIN: begin
                if (drain_q == DRN_W'(DET_LAT - 1)) state_d = ST_DONE;
                else                                 drain_d = drain_q + 1'b1;
            end
            ST_DONE: begin
                if (out_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        // Abort outranks every other transition; the LOAD it enters clears the detector.
        if (abort_take) begin
            state_d    = ST_LOAD;
            aborting_d = 1'b1;
        end
    end

    // ---------------- result collection ----------------
    always_comb begin
        hit_d = hit_q;
        map_d = map_q;
        if (accept || abort_take) begin
            hit_d = '0;
            map_d = '0;
        end else if (sample_en) begin
            map_d[pipe_idx_q[DET_LAT-1]] = det_z;
            if (det_z && (hit_q != CNT_W'(NSYM))) hit_d = hit_q + 1'b1;
        end
    end

    // ---------------- registers ----------------
    always_ff @(posedge clk) begin
        if (!clr_n) begin
            state_q    <= ST_IDLE;
            aborting_q <= 1'b0;
            drain_q    <= '0;
            det_clr_q  <= 1'b1;
            hit_q      <= '0;
            map_q      <= '0;
        end else begin
            state_q    <= state_d;
            aborting_q <= aborting_d;
            drain_q    <= drain_d;
            det_clr_q  <= (state_d == ST_LOAD);
            hit_q      <= hit_d;
            map_q      <= map_d;
        end
    end

    // NOTE: the tag pipe is a few flops, not a RAM, so it is reset like any other state.
    always_ff @(posedge clk) begin
        if (!clr_n || accept || abort_take) begin
            for (int i = 0; i < DET_LAT; i++) begin
                pipe_vld_q[i] <= 1'b0;
                pipe_idx_q[i] <= '0;
            end
        end else begin
            pipe_vld_q[0] <= (state_q == ST_SHIFT);
            pipe_idx_q[0] <= sh_idx;
            for (int i = 1; i < DET_LAT; i++) begin
                pipe_vld_q[i] <= pipe_vld_q[i-1];
                pipe_idx_q[i] <= pipe_idx_q[i-1];
            end
        end
    end

    // ---------------- outputs ----------------
    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = (state_q == ST_DONE);
    assign det_clr   = det_clr_q;
    assign det_b     = (state_q == ST_SHIFT) ? sh_sym[1] : 1'b0;
    assign det_a     = (state_q == ST_SHIFT) ? sh_sym[0] : 1'b0;
    assign hit_cnt   = hit_q;
    assign match_map = map_q;

endmodule
